// File: rtl/vga_fill_pkg.sv
// Shared types and widths for the VGA screen-fill sequencer.
package vga_fill_pkg;

    localparam int COORD_W = 9;
    localparam int COLOR_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    // Highest coordinate value for an axis holding `pixels` positions.
    function automatic logic [COORD_W-1:0] coord_last(input int pixels);
        return COORD_W'(pixels - 1);
    endfunction

endpackage

// File: rtl/vga_fill_fsm_pixel_counter.sv
// Nested column-major pixel counter: y is the inner (fast) axis, x the outer.
// Stops on the last pixel so the coordinates hold once the sweep is complete.
module pixel_counter
    import vga_fill_pkg::*;
#(
    parameter int X_PIXELS = 160,
    parameter int Y_PIXELS = 120
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               enable,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               last
);

    localparam logic [COORD_W-1:0] X_LAST = coord_last(X_PIXELS);
    localparam logic [COORD_W-1:0] Y_LAST = coord_last(Y_PIXELS);

    logic x_last;
    logic y_last;

    assign x_last = (x == X_LAST);
    assign y_last = (y == Y_LAST);
    assign last   = x_last && y_last;

    // Advance one pixel per enabled cycle; clear restarts the sweep at (0,0).
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values of its neighbours, matching hardware.
        if (reset) begin
            x <= '0;
            y <= '0;
        end else if (clear) begin
            x <= '0;
            y <= '0;
        end else if (enable && !last) begin
            if (!y_last) begin
                y <= y + 1'b1;
            end else begin
                y <= '0;
                // x never moves past its last column, even on a stray enable.
                if (!x_last) begin
                    x <= x + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/vga_fill_fsm.sv
// Screen-fill sequencer for the VGA adapter: on a start request, plots every
// pixel of the screen once in column-major order with colour stripes taken
// from the low bits of x. All outputs come straight from flops.
module vga_fill_fsm
    import vga_fill_pkg::*;
#(
    parameter int X_PIXELS = 160,
    parameter int Y_PIXELS = 120
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic               write,
    output logic [COLOR_W-1:0] color,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               write_out
);

    state_t             state;
    logic               cnt_clear;
    logic               cnt_enable;
    logic               cnt_last;
    logic [COORD_W-1:0] cnt_x;
    logic [COORD_W-1:0] cnt_y;

    // The counter is zeroed on the same edge that launches the fill, so the
    // first plotted pixel is (0,0) one cycle after write is sampled.
    assign cnt_clear  = (state == IDLE) && write;
    assign cnt_enable = (state == FILL) && !cnt_last;

    pixel_counter #(
        .X_PIXELS (X_PIXELS),
        .Y_PIXELS (Y_PIXELS)
    ) u_counter (
        .clk    (clk),
        .reset  (reset),
        .clear  (cnt_clear),
        .enable (cnt_enable),
        .x      (cnt_x),
        .y      (cnt_y),
        .last   (cnt_last)
    );

    // Colour is a pure function of the registered column: mod-8 stripes.
    assign x     = cnt_x;
    assign y     = cnt_y;
    assign color = cnt_x[COLOR_W-1:0];

    // Sequencer: IDLE waits for write, FILL plots one pixel per clock, DONE
    // holds until write drops so a held request yields exactly one fill.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            write_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (write) begin
                        state     <= FILL;
                        write_out <= 1'b1;
                    end else begin
                        write_out <= 1'b0;
                    end
                end
                FILL: begin
                    // The last pixel has been on the bus for one cycle when
                    // cnt_last is seen, so this edge ends the strobe.
                    if (cnt_last) begin
                        state     <= DONE;
                        write_out <= 1'b0;
                    end else begin
                        write_out <= 1'b1;
                    end
                end
                DONE: begin
                    write_out <= 1'b0;
                    if (!write) begin
                        state <= IDLE;
                    end
                end
                // NOTE: the unused encoding recovers to IDLE, so a corrupted
                // state register can never leave the strobe stuck high.
                default: begin
                    state     <= IDLE;
                    write_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_fill_fsm.sv
// Self-checking bench for vga_fill_fsm: table-driven reset/start vectors,
// a pixel scoreboard for full sweeps, a coverage bitmap, hold/re-arm and an
// asynchronous mid-fill reset.
module tb_vga_fill_fsm;

    localparam int XP   = 160;
    localparam int YP   = 120;
    localparam int NPIX = XP * YP;

    logic       clk = 1'b0;
    logic       reset;
    logic       write;
    logic [2:0] color;
    logic [8:0] x;
    logic [8:0] y;
    logic       write_out;

    vga_fill_fsm #(
        .X_PIXELS (XP),
        .Y_PIXELS (YP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .write     (write),
        .color     (color),
        .x         (x),
        .y         (y),
        .write_out (write_out)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int px;
        int py;
        int pc;
    } pix_t;

    typedef struct {
        logic rst;
        logic wr;
        logic exp_wo;
        int   ex;
        int   ey;
        int   ec;
    } vec_t;

    pix_t exp_q[$];
    int   hits[XP][YP];
    int   seen_col[XP][YP];
    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected pixel for sweep position idx, from the column-major order.
    function automatic pix_t pixel_at(input int idx);
        pix_t p;
        p.px = idx / YP;
        p.py = idx % YP;
        p.pc = (idx / YP) % 8;
        return p;
    endfunction

    task automatic push_sweep(input int first_idx);
        for (int i = first_idx; i < NPIX; i++) exp_q.push_back(pixel_at(i));
    endtask

    task automatic clear_bitmap();
        for (int i = 0; i < XP; i++)
            for (int j = 0; j < YP; j++) begin
                hits[i][j]     = 0;
                seen_col[i][j] = -1;
            end
    endtask

    task automatic mark_pixel();
        if (int'(x) < XP && int'(y) < YP) begin
            hits[x][y]++;
            seen_col[x][y] = int'(color);
        end else begin
            total++;
            bad++;
            $display("FAIL pixel_range: got (%0d,%0d), want inside %0dx%0d", x, y, XP, YP);
        end
    endtask

    task automatic check_bitmap(input string tag);
        int bad_cov = 0;
        int bad_map = 0;
        int bad8    = 0;
        int bad15   = 0;
        for (int i = 0; i < XP; i++)
            for (int j = 0; j < YP; j++) begin
                if (hits[i][j] != 1) bad_cov++;
                if (seen_col[i][j] != i % 8) bad_map++;
            end
        for (int j = 0; j < YP; j++) begin
            if (seen_col[8][j] != 0) bad8++;
            if (seen_col[15][j] != 7) bad15++;
        end
        check({tag, "_coverage_bad_pixels"}, bad_cov, 0);
        check({tag, "_color_map_bad_pixels"}, bad_map, 0);
        check({tag, "_stripe_x8_bad"}, bad8, 0);
        check({tag, "_stripe_x15_bad"}, bad15, 0);
    endtask

    // Consume the rest of a fill from the scoreboard, one sample per negedge,
    // then check the strobe dropped with the last pixel held on the bus.
    task automatic drain_fill(input string tag, input int highs_so_far);
        int   highs = highs_so_far;
        int   cyc   = 0;
        logic ended = 1'b0;
        pix_t e;
        while (cyc < NPIX + 16) begin
            @(negedge clk);
            cyc++;
            if (write_out !== 1'b1) begin
                ended = 1'b1;
                break;
            end
            highs++;
            mark_pixel();
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL %s_extra_pixel: got (%0d,%0d), want no more pixels", tag, x, y);
            end else begin
                e = exp_q.pop_front();
                total++;
                if (int'(x) != e.px || int'(y) != e.py || int'(color) != e.pc) begin
                    bad++;
                    $display("FAIL %s_pixel: got (%0d,%0d) c=%0d, want (%0d,%0d) c=%0d",
                             tag, x, y, color, e.px, e.py, e.pc);
                end
            end
        end
        check({tag, "_strobe_ended"}, int'(ended), 1);
        check({tag, "_fill_length"}, highs, NPIX);
        check({tag, "_scoreboard_left"}, exp_q.size(), 0);
        exp_q.delete();
        check({tag, "_hold_x"}, int'(x), XP - 1);
        check({tag, "_hold_y"}, int'(y), YP - 1);
        check({tag, "_hold_color"}, int'(color), 7);
    endtask

    // DONE needs write low for one edge before a new request is accepted.
    task automatic rearm_and_start();
        write = 1'b0;
        @(negedge clk);
        check("rearm_idle_write_out", int'(write_out), 0);
        write = 1'b1;
    endtask

    initial begin
        int   n_high;
        logic found;

        reset = 1'b1;
        write = 1'b0;
        clear_bitmap();

        // rst, wr -> write_out, x, y, color seen at the following negedge
        vecs[0] = '{1'b1, 1'b0, 1'b0, 0, 0, 0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 0, 0, 0};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 0, 0, 0};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 0, 0, 0};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 0, 0, 0};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 0, 1, 0};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 0, 2, 0};

        // Reset, idle, single-cycle start pulse and the first three pixels.
        for (int i = 0; i < 7; i++) begin
            reset = vecs[i].rst;
            write = vecs[i].wr;
            @(negedge clk);
            check($sformatf("vec%0d_write_out", i), int'(write_out), int'(vecs[i].exp_wo));
            check($sformatf("vec%0d_x", i), int'(x), vecs[i].ex);
            check($sformatf("vec%0d_y", i), int'(y), vecs[i].ey);
            check($sformatf("vec%0d_color", i), int'(color), vecs[i].ec);
            if (write_out === 1'b1) mark_pixel();
        end

        // Fill 1: rest of the sweep after a one-cycle write pulse.
        push_sweep(3);
        drain_fill("fill1", 3);
        check_bitmap("fill1");

        // Fill 2: write held high through the whole fill and past DONE.
        rearm_and_start();
        clear_bitmap();
        push_sweep(0);
        drain_fill("fill2", 0);
        check_bitmap("fill2");
        n_high = 0;
        repeat (40) begin
            @(negedge clk);
            if (write_out === 1'b1) n_high++;
        end
        check("held_write_no_refill", n_high, 0);
        check("held_write_x_hold", int'(x), XP - 1);

        // Fill 3: drop write, raise again -> a second full sweep from (0,0).
        rearm_and_start();
        clear_bitmap();
        push_sweep(0);
        drain_fill("fill3", 0);
        check_bitmap("fill3");

        // Fill 4: abort with an asynchronous reset while (37,50) is on the bus.
        rearm_and_start();
        @(negedge clk);
        write = 1'b0;
        found = 1'b0;
        if (write_out === 1'b1 && x == 9'd0 && y == 9'd0) begin
            for (int c = 0; c < NPIX; c++) begin
                if (write_out === 1'b1 && x == 9'd37 && y == 9'd50) begin
                    found = 1'b1;
                    break;
                end
                @(negedge clk);
            end
        end
        check("midfill_reached_37_50", int'(found), 1);
        #2 reset = 1'b1;
        #1;
        check("async_reset_write_out", int'(write_out), 0);
        check("async_reset_x", int'(x), 0);
        check("async_reset_y", int'(y), 0);
        check("async_reset_color", int'(color), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        n_high = 0;
        repeat (6) begin
            @(negedge clk);
            if (write_out !== 1'b0 || x != 9'd0 || y != 9'd0) n_high++;
        end
        check("post_reset_stays_idle", n_high, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
